fifo_rd_ctrl: RTL and testbench

Read-side controller for the dual-clock FIFO, the counterpart of the write-pointer/full logic. It lives entirely in the read clock domain. It consumes the synchronized gray write pointer (`rq2_wptr`), owns the gray read pointer `rptr` handed to the read-to-write synchronizer, and drives the FIFO memory read port. Popped words are presented to the consumer through a 2-entry first-word-fall-through output buffer with a valid/ready handshake, plus empty, almost-empty and level status.

---
 rtl/fifo_pkg.sv | 29 ++
 rtl/fifo_rd_ctrl_if.sv | 15 +
 rtl/fifo_out_buf.sv | 71 +++++++
 rtl/fifo_rd_ctrl.sv | 78 +++++++
 tb/tb_fifo_rd_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared dual-clock FIFO helpers: gray/binary conversion and default sizes.
// Both the read and write controllers import this package.
package fifo_pkg;

   localparam int unsigned DSIZE_DEFAULT = 32;
   localparam int unsigned ASIZE_DEFAULT = 8;

   // Widest pointer the helpers support; callers cast to and from their own width.
   localparam int unsigned PTR_MAX = 32;

   typedef logic [PTR_MAX-1:0] ptr_t;

   function automatic ptr_t bin2gray(input ptr_t b);
      return b ^ (b >> 1);
   endfunction

   // Prefix XOR from the MSB down; zero-extended upper bits do not disturb the result.
   function automatic ptr_t gray2bin(input ptr_t g);
      ptr_t b;
      b = g;
      b = b ^ (b >> 1);
      b = b ^ (b >> 2);
      b = b ^ (b >> 4);
      b = b ^ (b >> 8);
      b = b ^ (b >> 16);
      return b;
   endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// Consumer-side valid/ready stream of the FIFO read controller.
interface fifo_rd_ctrl_if
   import fifo_pkg::*;
#(
   parameter int unsigned DSIZE = DSIZE_DEFAULT
);

   logic [DSIZE-1:0] rdata;
   logic             rvalid;
   logic             rready;

   modport master (output rdata, output rvalid, input rready);
   modport slave  (input rdata, input rvalid, output rready);

endinterface

// File: rtl/fifo_out_buf.sv
// Two-entry first-word-fall-through skid buffer behind the FIFO memory read port.
module fifo_out_buf
   import fifo_pkg::*;
#(
   parameter int unsigned DSIZE = DSIZE_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             capture,
   input  logic [DSIZE-1:0] cdata,
   input  logic             pop,
   output logic [DSIZE-1:0] head,
   output logic             valid,
   output logic [1:0]       occ
);

   logic [DSIZE-1:0] head_q, head_d;
   logic [DSIZE-1:0] tail_q, tail_d;
   logic [1:0]       occ_q, occ_d;
   logic             valid_q;

   // Next-state: the head register always holds the oldest word.
   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      occ_d  = occ_q;
      case ({capture, pop})
         2'b10: begin
            if (occ_q == 2'd0) begin
               head_d = cdata;
            end else begin
               tail_d = cdata;
            end
            occ_d = occ_q + 2'd1;
         end
         2'b01: begin
            head_d = tail_q;
            occ_d  = occ_q - 2'd1;
         end
         2'b11: begin
            if (occ_q == 2'd1) begin
               head_d = cdata;
            end else begin
               head_d = tail_q;
               tail_d = cdata;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         occ_q   <= 2'd0;
         valid_q <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         occ_q   <= occ_d;
         valid_q <= (occ_d != 2'd0);
      end
   end

   assign head  = head_q;
   assign valid = valid_q;
   assign occ   = occ_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller of the dual-clock FIFO: read pointer, empty/level status,
// memory read issue, and a 2-entry FWFT output stage toward the consumer.
module fifo_rd_ctrl
   import fifo_pkg::*;
#(
   parameter int unsigned DSIZE     = DSIZE_DEFAULT,
   parameter int unsigned ASIZE     = ASIZE_DEFAULT,
   parameter int unsigned AEMPTY_TH = 4
) (
   input  logic               rclk,
   input  logic               rrst,
   input  logic [ASIZE:0]     rq2_wptr,
   output logic [ASIZE:0]     rptr,
   output logic [ASIZE-1:0]   raddr,
   output logic               rmem_en,
   input  logic [DSIZE-1:0]   rmem_data,
   fifo_rd_ctrl_if.master     rd,
   output logic               rempty,
   output logic               ralmost_empty,
   output logic [ASIZE:0]     rlevel
);

   localparam int unsigned PW = ASIZE + 1;

   logic [PW-1:0] rbin;
   logic [PW-1:0] rbin_next;
   logic [PW-1:0] rgray_next;
   logic [PW-1:0] wbin_sync;
   logic [PW-1:0] level_next;
   logic          inflight;
   logic          pop;
   logic [1:0]    occ;
   logic [2:0]    demand;

   // Issue only when the buffer can still absorb the word after this cycle's pop.
   assign pop     = rd.rvalid & rd.rready;
   assign demand  = 3'(occ) + 3'(inflight) - 3'(pop);
   assign rmem_en = !rempty && (demand < 3'd2);

   assign rbin_next  = rbin + PW'(rmem_en);
   assign rgray_next = PW'(bin2gray(PTR_MAX'(rbin_next)));
   assign wbin_sync  = PW'(gray2bin(PTR_MAX'(rq2_wptr)));
   assign level_next = wbin_sync - rbin_next;
   assign raddr      = rbin[ASIZE-1:0];

   // Pointer and status registers; status reflects the post-read pointer.
   always_ff @(posedge rclk) begin
      if (rrst) begin
         rbin          <= '0;
         rptr          <= '0;
         rempty        <= 1'b1;
         rlevel        <= '0;
         ralmost_empty <= 1'b1;
         inflight      <= 1'b0;
      end else begin
         rbin          <= rbin_next;
         rptr          <= rgray_next;
         rempty        <= (rgray_next == rq2_wptr);
         rlevel        <= level_next;
         ralmost_empty <= (32'(level_next) <= AEMPTY_TH);
         inflight      <= rmem_en;
      end
   end

   fifo_out_buf #(
      .DSIZE (DSIZE)
   ) u_buf (
      .clk     (rclk),
      .rst     (rrst),
      .capture (inflight),
      .cdata   (rmem_data),
      .pop     (pop),
      .head    (rd.rdata),
      .valid   (rd.rvalid),
      .occ     (occ)
   );

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl with a queue scoreboard of written words.
module tb_fifo_rd_ctrl;
   import fifo_pkg::*;

   localparam int unsigned DW = 8;
   localparam int unsigned AW = 3;
   localparam int unsigned PW = 4;
   localparam int unsigned TH = 2;

   logic          rclk = 1'b0;
   logic          rrst;
   logic [PW-1:0] rq2_wptr;
   logic [PW-1:0] rptr;
   logic [AW-1:0] raddr;
   logic          rmem_en;
   logic [DW-1:0] rmem_data;
   logic          rempty;
   logic          ralmost_empty;
   logic [PW-1:0] rlevel;

   fifo_rd_ctrl_if #(.DSIZE(DW)) rd_if ();

   fifo_rd_ctrl #(
      .DSIZE     (DW),
      .ASIZE     (AW),
      .AEMPTY_TH (TH)
   ) dut (
      .rclk          (rclk),
      .rrst          (rrst),
      .rq2_wptr      (rq2_wptr),
      .rptr          (rptr),
      .raddr         (raddr),
      .rmem_en       (rmem_en),
      .rmem_data     (rmem_data),
      .rd            (rd_if),
      .rempty        (rempty),
      .ralmost_empty (ralmost_empty),
      .rlevel        (rlevel)
   );

   always #5 rclk = ~rclk;

   // Synchronous-read memory with one cycle of latency.
   logic [DW-1:0] mem [8];
   always @(posedge rclk) begin
      if (rmem_en) rmem_data <= mem[raddr];
   end

   int            errors;
   int            checks;
   logic [DW-1:0] q [$];
   logic [PW-1:0] wbin;
   int            pops;
   int            issued;
   int            sent;
   int            cyc;
   int            budget;
   int            first_pop;
   int            last_pop;
   int            lvl_prev;
   logic          toggle;
   logic          mon_addr;
   logic          saw_wrap;
   logic          last_flag;
   logic [PW-1:0] prev_rptr;

   function automatic logic [PW-1:0] g(input int unsigned b);
      logic [PW-1:0] t;
      t = PW'(b);
      return PW'(bin2gray(PTR_MAX'(t)));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Write side: store a word, record it, and publish the new gray write pointer.
   task automatic push(input logic [DW-1:0] d);
      assert (q.size() < 8)
      else $fatal(1, "FAIL push: write pointer would lead read side by more than depth");
      mem[wbin[AW-1:0]] = d;
      q.push_back(d);
      wbin     = wbin + PW'(1);
      rq2_wptr = g(32'(wbin));
   endtask

   // One clock: monitor at the falling edge, then return just after the rising edge.
   task automatic tick();
      logic [DW-1:0] exp;
      @(negedge rclk);
      cyc++;
      if (rd_if.rvalid && rd_if.rready) begin
         if (q.size() != 0) exp = q.pop_front();
         else exp = 'x;
         chk("pop_data", 32'(rd_if.rdata), 32'(exp));
         pops++;
         if (mon_addr) begin
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
         end
      end
      if (mon_addr) begin
         if (rmem_en) begin
            chk("raddr_seq", 32'(raddr), 32'(issued % 8));
            issued++;
            if (issued == 20) begin
               chk("last_occ", 32'(dut.occ), 1);
               chk("last_pop", 32'(rd_if.rvalid & rd_if.rready), 1);
               chk("last_rempty_pre", 32'(rempty), 0);
               last_flag = 1'b1;
            end
         end
         if (prev_rptr == g(15) && rptr != prev_rptr) begin
            chk("rptr_wrap", 32'(rptr), 32'(g(0)));
            saw_wrap = 1'b1;
         end
         prev_rptr = rptr;
      end
      @(posedge rclk);
      #1;
   endtask

   initial begin
      errors = 0; checks = 0; pops = 0; issued = 0; sent = 0; cyc = 0;
      first_pop = -1; last_pop = -1; lvl_prev = 0; toggle = 1'b1;
      mon_addr = 1'b0; saw_wrap = 1'b0; last_flag = 1'b0; prev_rptr = '0;
      q.delete();
      wbin = '0; rq2_wptr = '0; rrst = 1'b1; rd_if.rready = 1'b0;
      for (int i = 0; i < 8; i++) mem[i] = '0;

      // Reset held for two cycles
      tick(); tick();
      rrst = 1'b0;
      chk("rst_rempty", 32'(rempty), 1);
      chk("rst_rvalid", 32'(rd_if.rvalid), 0);
      chk("rst_rptr", 32'(rptr), 0);
      chk("rst_rlevel", 32'(rlevel), 0);
      chk("rst_aempty", 32'(ralmost_empty), 1);
      chk("rst_rmem_en", 32'(rmem_en), 0);

      // Single word: pointer steps in cycle N
      push(8'hA5);
      chk("sw_en_n", 32'(rmem_en), 0);
      tick();
      chk("sw_rempty_n1", 32'(rempty), 0);
      chk("sw_en_n1", 32'(rmem_en), 1);
      chk("sw_raddr", 32'(raddr), 0);
      tick();
      chk("sw_rempty_n2", 32'(rempty), 1);
      chk("sw_rptr_n2", 32'(rptr), 32'(g(1)));
      chk("sw_rvalid_n2", 32'(rd_if.rvalid), 0);
      tick();
      chk("sw_rvalid_n3", 32'(rd_if.rvalid), 1);
      chk("sw_rdata_n3", 32'(rd_if.rdata), 32'h0000_00A5);
      rd_if.rready = 1'b1;
      tick();
      rd_if.rready = 1'b0;
      chk("sw_rvalid_post", 32'(rd_if.rvalid), 0);
      chk("sw_rempty_post", 32'(rempty), 1);
      chk("sw_rptr_post", 32'(rptr), 32'(g(1)));
      chk("sw_pops", 32'(pops), 1);

      // Full drain of 8 words with rready toggling
      for (int i = 0; i < 8; i++) push(8'(8'h30 + i));
      tick();
      chk("drain_lvl_full", 32'(rlevel), 8);
      chk("drain_aempty_full", 32'(ralmost_empty), 0);
      lvl_prev = 8;
      budget = 0;
      while (pops < 9 && budget < 60) begin
         rd_if.rready = toggle;
         toggle = ~toggle;
         chk("drain_occ_le2", 32'(dut.occ <= 2'd2), 1);
         chk("drain_lvl_mono", 32'(int'(rlevel) <= lvl_prev), 1);
         chk("drain_aempty", 32'(ralmost_empty), 32'(rlevel <= PW'(TH)));
         lvl_prev = int'(rlevel);
         tick();
         budget++;
      end
      rd_if.rready = 1'b0;
      chk("drain_pops", 32'(pops), 9);
      chk("drain_lvl_zero", 32'(rlevel), 0);
      chk("drain_aempty_end", 32'(ralmost_empty), 1);
      chk("drain_rempty_end", 32'(rempty), 1);

      // Wrap-around stream of 20 words, both domains reset first
      rrst = 1'b1; wbin = '0; rq2_wptr = '0; q.delete();
      tick();
      rrst = 1'b0;
      pops = 0; issued = 0; first_pop = -1; last_pop = -1;
      prev_rptr = rptr; mon_addr = 1'b1;
      for (int i = 0; i < 8; i++) push(8'(8'h50 + i));
      sent = 8;
      rd_if.rready = 1'b1;
      budget = 0;
      while (pops < 20 && budget < 100) begin
         if (sent < 20 && q.size() < 8) begin
            push(8'(8'h50 + sent));
            sent++;
         end
         tick();
         budget++;
         if (last_flag) begin
            chk("last_rempty_post", 32'(rempty), 1);
            chk("last_rptr_post", 32'(rptr), 32'(g(20)));
            chk("last_occ_post", 32'(dut.occ), 1);
            last_flag = 1'b0;
         end
      end
      mon_addr = 1'b0;
      chk("wrap_pops", 32'(pops), 20);
      chk("wrap_issued", 32'(issued), 20);
      chk("wrap_seen", 32'(saw_wrap), 1);
      chk("wrap_throughput", 32'(last_pop - first_pop), 19);

      // Mid-stream reset with a buffered word and a read in flight
      rd_if.rready = 1'b0;
      for (int i = 0; i < 4; i++) push(8'(8'h70 + i));
      tick(); tick(); tick();
      chk("mr_occ_pre", 32'(dut.occ), 1);
      chk("mr_inflight_pre", 32'(dut.inflight), 1);
      chk("mr_rdata_pre", 32'(rd_if.rdata), 32'h0000_0070);
      rrst = 1'b1; wbin = '0; rq2_wptr = '0; q.delete();
      tick();
      rrst = 1'b0;
      chk("mr_rempty", 32'(rempty), 1);
      chk("mr_rvalid", 32'(rd_if.rvalid), 0);
      chk("mr_rdata", 32'(rd_if.rdata), 0);
      chk("mr_rptr", 32'(rptr), 0);
      chk("mr_rlevel", 32'(rlevel), 0);
      chk("mr_aempty", 32'(ralmost_empty), 1);
      chk("mr_rmem_en", 32'(rmem_en), 0);
      chk("mr_occ", 32'(dut.occ), 0);
      chk("mr_inflight", 32'(dut.inflight), 0);
      rd_if.rready = 1'b1;
      tick(); tick();
      chk("mr_rvalid_late", 32'(rd_if.rvalid), 0);
      chk("mr_rempty_late", 32'(rempty), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
